bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Arbiter and bus multiplexer for the shared single-bit serial bus. It accepts bus requests from up to `NUM_MASTERS` serial bus masters and grants the bus to one master at a time. It holds the grant until that master signals completion or drops its request. It steers the granted master's `B_BUS_OUT`/`B_RW`/`B_UTIL` onto the slave-side bus and reclaims the bus from a stalled owner with an idle timeout.

## Interface
Parameters:
- `NUM_MASTERS`, default 2: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 64: consecutive idle cycles (owner `M_UTIL` low) before a forced release, 2..255.

Ports (one clock; reset is asynchronous and active-low):
- `CLK`, in, 1: clock; all state updates on the rising edge.
- `RSTN`, in, 1: asynchronous active-low reset.
- `M_REQ`, in, `NUM_MASTERS`: per-master `B_REQ`.
- `M_UTIL`, in, `NUM_MASTERS`: per-master `B_UTIL`.
- `M_DONE`, in, `NUM_MASTERS`: per-master `B_DONE`.
- `M_RW`, in, `NUM_MASTERS`: per-master `B_RW`.
- `M_BUS_OUT`, in, `NUM_MASTERS`: per-master serial data toward the slaves.
- `M_GRANT`, out, `NUM_MASTERS`: one-hot `B_GRANT` per master; all zero when no master owns the bus.
- `GRANT_ID`, out, `$clog2(NUM_MASTERS)`: index of the current owner; holds its last value when no grant is active.
- `S_BUS_OUT`, out, 1: muxed serial data to the slaves.
- `S_RW`, out, 1: muxed read/write to the slaves.
- `S_UTIL`, out, 1: muxed utilisation to the slaves.
- `BUS_BSY`, out, 1: high while in state GRANTED or BUSY.
- `TIMEOUT`, out, 1: one-cycle pulse on a forced release.

## Operation
State machine `state`, with reset state IDLE:
- **IDLE**
  - If `M_REQ != 0`, select a winner `w` per the priority rule.
  - Register `M_GRANT = 1<<w` and `GRANT_ID = w`, then go to GRANTED.
  - Otherwise stay in IDLE.
- **GRANTED**
  - If `M_UTIL[w]`, go to BUSY.
  - If `~M_REQ[w]`, go to RELEASE.
  - If the idle counter reaches `TIMEOUT_CYCLES-1`, go to RELEASE and pulse `TIMEOUT`.
- **BUSY**
  - If `M_DONE[w]` or `~M_REQ[w]`, go to RELEASE.
  - Otherwise apply the same timeout check as GRANTED.
- **RELEASE**
  - Clear `M_GRANT` to all zero for exactly one cycle.
  - Update the priority pointer, then go to IDLE.

Idle counter:
- 8 bits wide.
- Cleared on entry to GRANTED.
- Cleared on any cycle with `M_UTIL[w]=1`.
- Incremented otherwise while in GRANTED or BUSY.
- Saturates and never wraps.

Multiplexer:
- `S_BUS_OUT = M_BUS_OUT[GRANT_ID] & |M_GRANT`. `S_RW` and `S_UTIL` are formed the same way.
- The mux is combinational from registered grant state.
- All three outputs are 0 when no grant is active.

Other rules:
- Requests from non-owners are ignored until the bus returns to IDLE; there is no preemption except by timeout.
- A master whose `M_REQ` is high when its own grant drops stays eligible in the next arbitration.

## Timing
- Reset values:
  - `M_GRANT=0`, `GRANT_ID=0`, `BUS_BSY=0`, `TIMEOUT=0`.
  - `S_BUS_OUT=0`, `S_RW=0`, `S_UTIL=0`.
  - Idle counter 0, priority pointer 0, state IDLE.
- Grant latency: `M_REQ` sampled high in IDLE at edge t gives `M_GRANT` high after edge t (visible in cycle t+1).
- Release: a done or request drop sampled at edge t deasserts `M_GRANT` after edge t+1. The earliest next grant is after edge t+3, giving a minimum 2-cycle bus gap (RELEASE, then IDLE).
- Simultaneous `M_DONE[w]` and `~M_REQ[w]` cause a single release and no `TIMEOUT`.
- If a timeout and `M_DONE[w]` occur on the same edge, `M_DONE` wins and `TIMEOUT` stays 0.
- `M_DONE`/`M_UTIL` from non-owners are ignored.
- Assertion of `RSTN` at any point, including mid-transfer, immediately returns all outputs to their reset values.

## Configuration
- `BUS_ARB_ROUND_ROBIN_EN` defined:
  - Rotating priority.
  - The search starts at `(last_owner+1) mod NUM_MASTERS`.
  - The pointer is updated in RELEASE.
- Not defined:
  - Fixed priority: the lowest index wins.
  - The pointer register is absent.

## Test plan
- Single request: `M_REQ=01` in IDLE -> `M_GRANT=01` one cycle later and `BUS_BSY=1`. Then `M_UTIL[0]=1` -> BUSY, and `S_UTIL=1` follows the owner's `M_UTIL`. Then `M_DONE[0]` pulse -> `M_GRANT=00` two edges later.
- Contention: `M_REQ=11` held continuously, each owner completing with `M_DONE`.
  - With `BUS_ARB_ROUND_ROBIN_EN`: grants alternate 0,1,0,1.
  - Without it: grants are always to master 0, and master 1 gets none.
- Request drop before use: grant to master 1, then `M_REQ[1]=0` with `M_UTIL[1]` never high -> RELEASE, `M_GRANT=00`, `TIMEOUT=0`.
- Timeout, with `TIMEOUT_CYCLES=8`: owner holds `M_REQ` with `M_UTIL` low -> `TIMEOUT` pulses once after 8 idle cycles and the grant is withdrawn. A single `M_UTIL` high mid-count restarts the count.
- Mux isolation: with master 0 granted, toggle `M_BUS_OUT[1]`/`M_RW[1]` -> `S_BUS_OUT`/`S_RW` track master 0 only. With no grant, all S outputs are 0.
- Reset mid-transfer: `RSTN=0` during BUSY -> all outputs 0 asynchronously. After release, with `M_REQ=10`, master 1 is granted one cycle later.

Source files
------------

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Arbiter and slave-side multiplexer for the shared single-bit
//                serial bus. Grants one master at a time, holds the grant
//                until done / request drop, reclaims a stalled bus after an
//                idle timeout, and steers the owner's signals to the slaves.
//                Optional macro BUS_ARB_ROUND_ROBIN_EN selects rotating
//                priority; without it the lowest requesting index wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                           CLK,
   input  logic                           RSTN,
   input  logic [NUM_MASTERS-1:0]         M_REQ,
   input  logic [NUM_MASTERS-1:0]         M_UTIL,
   input  logic [NUM_MASTERS-1:0]         M_DONE,
   input  logic [NUM_MASTERS-1:0]         M_RW,
   input  logic [NUM_MASTERS-1:0]         M_BUS_OUT,
   output logic [NUM_MASTERS-1:0]         M_GRANT,
   output logic [$clog2(NUM_MASTERS)-1:0] GRANT_ID,
   output logic                           S_BUS_OUT,
   output logic                           S_RW,
   output logic                           S_UTIL,
   output logic                           BUS_BSY,
   output logic                           TIMEOUT
);

   localparam int                     IDW        = $clog2(NUM_MASTERS);
   localparam logic [7:0]             IDLE_LIMIT = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [NUM_MASTERS-1:0] ONE_HOT0   = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANTED = 2'd1,
      ST_BUSY    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t                 state;
   logic [NUM_MASTERS-1:0] grant;
   logic [IDW-1:0]         grant_id;
   logic                   busy;
   logic                   timeout_pulse;
   logic [7:0]             idle_cnt;
   // RELEASE spans two cycles: grant dropped in the first, pointer/IDLE in the second
   logic                   rel_phase;

   logic [IDW-1:0]         search_start;
   logic [IDW-1:0]         winner;
   logic                   owner_req;
   logic                   owner_util;
   logic                   owner_done;
   logic                   grant_active;
   logic                   cnt_hit;

   // First requester found when scanning upward (with wrap) from start
   function automatic logic [IDW-1:0] pick_winner(input logic [NUM_MASTERS-1:0] req,
                                                  input logic [IDW-1:0]         start);
      logic [IDW-1:0] w;
      logic           found;
      int             idx;
      w     = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         idx = (int'(start) + k) % NUM_MASTERS;
         if (!found && req[IDW'(idx)]) begin
            w     = IDW'(idx);
            found = 1'b1;
         end
      end
      return w;
   endfunction

`ifdef BUS_ARB_ROUND_ROBIN_EN
   logic [IDW-1:0] rr_ptr;

   // Move the search start just past the owner that is giving up the bus
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rr_ptr <= '0;
      end else if (state == ST_RELEASE && !rel_phase) begin
         rr_ptr <= (int'(grant_id) == NUM_MASTERS - 1) ? '0 : grant_id + 1'b1;
      end
   end

   assign search_start = rr_ptr;
`else
   assign search_start = '0;
`endif

   // Arbitration result for the current request vector
   always_comb begin
      winner = pick_winner(M_REQ, search_start);
   end

   // Only the owner's handshake bits are ever looked at
   assign owner_req    = M_REQ[grant_id];
   assign owner_util   = M_UTIL[grant_id];
   assign owner_done   = M_DONE[grant_id];
   assign grant_active = |grant;
   assign cnt_hit      = (idle_cnt == IDLE_LIMIT);

   // Arbitration FSM with registered grant, busy and timeout outputs
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state         <= ST_IDLE;
         grant         <= '0;
         grant_id      <= '0;
         busy          <= 1'b0;
         timeout_pulse <= 1'b0;
         idle_cnt      <= 8'd0;
         rel_phase     <= 1'b0;
      end else begin
         timeout_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|M_REQ) begin
                  grant    <= ONE_HOT0 << winner;
                  grant_id <= winner;
                  busy     <= 1'b1;
                  idle_cnt <= 8'd0;
                  state    <= ST_GRANTED;
               end
            end
            ST_GRANTED: begin
               if (!owner_req) begin
                  busy  <= 1'b0;
                  state <= ST_RELEASE;
               end else if (owner_util) begin
                  idle_cnt <= 8'd0;
                  state    <= ST_BUSY;
               end else if (cnt_hit) begin
                  busy          <= 1'b0;
                  timeout_pulse <= 1'b1;
                  state         <= ST_RELEASE;
               end else if (idle_cnt != 8'hFF) begin
                  idle_cnt <= idle_cnt + 8'd1;
               end
            end
            ST_BUSY: begin
               // completion and request drop take precedence over the timeout
               if (owner_done || !owner_req) begin
                  busy  <= 1'b0;
                  state <= ST_RELEASE;
               end else if (owner_util) begin
                  idle_cnt <= 8'd0;
               end else if (cnt_hit) begin
                  busy          <= 1'b0;
                  timeout_pulse <= 1'b1;
                  state         <= ST_RELEASE;
               end else if (idle_cnt != 8'hFF) begin
                  idle_cnt <= idle_cnt + 8'd1;
               end
            end
            ST_RELEASE: begin
               if (!rel_phase) begin
                  grant     <= '0;
                  rel_phase <= 1'b1;
               end else begin
                  rel_phase <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign M_GRANT   = grant;
   assign GRANT_ID  = grant_id;
   assign BUS_BSY   = busy;
   assign TIMEOUT   = timeout_pulse;

   // Slave-side mux, forced low whenever nobody owns the bus
   assign S_BUS_OUT = M_BUS_OUT[grant_id] & grant_active;
   assign S_RW      = M_RW[grant_id]      & grant_active;
   assign S_UTIL    = M_UTIL[grant_id]    & grant_active;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Directed self-checking bench for bus_arbiter (2 masters,
//                8-cycle idle timeout). Expected owners follow the build's
//                BUS_ARB_ROUND_ROBIN_EN setting.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

   logic       CLK;
   logic       RSTN;
   logic [1:0] M_REQ;
   logic [1:0] M_UTIL;
   logic [1:0] M_DONE;
   logic [1:0] M_RW;
   logic [1:0] M_BUS_OUT;
   logic [1:0] M_GRANT;
   logic [0:0] GRANT_ID;
   logic       S_BUS_OUT;
   logic       S_RW;
   logic       S_UTIL;
   logic       BUS_BSY;
   logic       TIMEOUT;

   int n_checks = 0;
   int n_fail   = 0;

   bus_arbiter #(
      .NUM_MASTERS    (2),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .M_REQ     (M_REQ),
      .M_UTIL    (M_UTIL),
      .M_DONE    (M_DONE),
      .M_RW      (M_RW),
      .M_BUS_OUT (M_BUS_OUT),
      .M_GRANT   (M_GRANT),
      .GRANT_ID  (GRANT_ID),
      .S_BUS_OUT (S_BUS_OUT),
      .S_RW      (S_RW),
      .S_UTIL    (S_UTIL),
      .BUS_BSY   (BUS_BSY),
      .TIMEOUT   (TIMEOUT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // advance one rising edge and settle just after it
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // owner of contention round r with both masters requesting throughout
   function automatic int exp_owner(input int r);
`ifdef BUS_ARB_ROUND_ROBIN_EN
      // pointer sits at 1 after the earlier master-0-only transfers
      return (r % 2 == 0) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"},   32'(M_GRANT),   32'd0);
      chk({tag, "_bsy"},     32'(BUS_BSY),   32'd0);
      chk({tag, "_timeout"}, 32'(TIMEOUT),   32'd0);
      chk({tag, "_s_bus"},   32'(S_BUS_OUT), 32'd0);
      chk({tag, "_s_rw"},    32'(S_RW),      32'd0);
      chk({tag, "_s_util"},  32'(S_UTIL),    32'd0);
   endtask

   initial begin
      RSTN      = 1'b0;
      M_REQ     = 2'b00;
      M_UTIL    = 2'b00;
      M_DONE    = 2'b00;
      M_RW      = 2'b00;
      M_BUS_OUT = 2'b00;

      // ---------------- reset values ----------------
      @(posedge CLK);
      #2;
      chk_all_zero("reset");
      chk("reset_grant_id", 32'(GRANT_ID), 32'd0);
      @(negedge CLK);
      RSTN = 1'b1;
      tick();
      chk("idle_no_req", 32'(M_GRANT), 32'd0);

      // ---------------- single request ----------------
      M_REQ = 2'b01;
      tick();
      chk("single_grant",    32'(M_GRANT),  32'h1);
      chk("single_grant_id", 32'(GRANT_ID), 32'd0);
      chk("single_bsy",      32'(BUS_BSY),  32'd1);
      chk("single_s_util0",  32'(S_UTIL),   32'd0);
      M_UTIL = 2'b01;
      #1;
      chk("single_s_util1",  32'(S_UTIL),   32'd1);
      tick();
      chk("busy_grant",      32'(M_GRANT),  32'h1);
      chk("busy_bsy",        32'(BUS_BSY),  32'd1);

      // ---------------- mux isolation with master 0 owning ----------------
      M_UTIL    = 2'b00;
      M_BUS_OUT = 2'b10;
      M_RW      = 2'b10;
      #1;
      chk("iso_s_util",  32'(S_UTIL),    32'd0);
      chk("iso_s_bus0",  32'(S_BUS_OUT), 32'd0);
      chk("iso_s_rw0",   32'(S_RW),      32'd0);
      M_BUS_OUT = 2'b01;
      M_RW      = 2'b01;
      #1;
      chk("iso_s_bus1",  32'(S_BUS_OUT), 32'd1);
      chk("iso_s_rw1",   32'(S_RW),      32'd1);
      M_BUS_OUT = 2'b00;
      M_RW      = 2'b00;

      // ---------------- done pulse and bus gap ----------------
      M_DONE = 2'b01;
      tick();                                   // edge t
      M_DONE = 2'b00;
      chk("done_t_grant",   32'(M_GRANT), 32'h1);
      chk("done_t_bsy",     32'(BUS_BSY), 32'd0);
      tick();                                   // edge t+1
      chk("done_t1_grant",  32'(M_GRANT), 32'h0);
      chk("done_t1_tmo",    32'(TIMEOUT), 32'd0);
      tick();                                   // edge t+2
      chk("gap_t2_grant",   32'(M_GRANT), 32'h0);
      tick();                                   // edge t+3
      chk("regrant_t3",     32'(M_GRANT), 32'h1);

      // simultaneous done and request drop
      M_DONE = 2'b01;
      M_REQ  = 2'b00;
      tick();
      M_DONE = 2'b00;
      chk("done_drop_tmo",  32'(TIMEOUT), 32'd0);
      tick();
      chk("done_drop_grant", 32'(M_GRANT), 32'h0);
      chk("done_drop_tmo2",  32'(TIMEOUT), 32'd0);
      tick();

      // ---------------- contention ----------------
      M_REQ = 2'b11;
      tick();
      for (int r = 0; r < 4; r++) begin
         chk($sformatf("cont%0d_grant", r), 32'(M_GRANT),  32'(1 << exp_owner(r)));
         chk($sformatf("cont%0d_id", r),    32'(GRANT_ID), 32'(exp_owner(r)));
         M_UTIL = 2'b11;
         tick();
         M_UTIL = 2'b00;
         M_DONE = 2'b11;
         tick();
         M_DONE = 2'b00;
         tick();
         chk($sformatf("cont%0d_gap", r), 32'(M_GRANT), 32'h0);
         tick();
         tick();
      end
      M_REQ = 2'b00;
      tick();
      tick();
      tick();

      // ---------------- request drop before use (master 1) ----------------
      M_REQ = 2'b10;
      tick();
      chk("drop_grant",    32'(M_GRANT),  32'h2);
      chk("drop_grant_id", 32'(GRANT_ID), 32'd1);
      M_REQ = 2'b00;
      tick();
      chk("drop_rel_tmo",  32'(TIMEOUT),  32'd0);
      tick();
      chk("drop_grant0",   32'(M_GRANT),  32'h0);
      chk("drop_tmo0",     32'(TIMEOUT),  32'd0);
      tick();
      chk("drop_id_hold",  32'(GRANT_ID), 32'd1);

      // no grant: slave outputs stay low whatever the masters drive
      M_BUS_OUT = 2'b11;
      M_RW      = 2'b11;
      M_UTIL    = 2'b11;
      #1;
      chk("nogrant_s_bus",  32'(S_BUS_OUT), 32'd0);
      chk("nogrant_s_rw",   32'(S_RW),      32'd0);
      chk("nogrant_s_util", 32'(S_UTIL),    32'd0);
      M_BUS_OUT = 2'b00;
      M_RW      = 2'b00;
      M_UTIL    = 2'b00;
      tick();

      // ---------------- timeout from GRANTED (master 1) ----------------
      M_REQ = 2'b10;
      tick();                                   // grant edge
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk($sformatf("tmo_g_quiet%0d", i), 32'(TIMEOUT), 32'd0);
      end
      tick();                                   // 8th idle cycle
      chk("tmo_g_pulse",  32'(TIMEOUT), 32'd1);
      chk("tmo_g_bsy",    32'(BUS_BSY), 32'd0);
      tick();
      chk("tmo_g_once",   32'(TIMEOUT), 32'd0);
      chk("tmo_g_grant0", 32'(M_GRANT), 32'h0);
      M_REQ = 2'b00;
      tick();
      tick();

      // ---------------- timeout restart by one M_UTIL pulse ----------------
      M_REQ = 2'b01;
      tick();                                   // E0 grant
      tick();
      tick();
      tick();                                   // E3: three idle cycles
      M_UTIL = 2'b01;
      tick();                                   // E4: count restarts, BUSY
      M_UTIL = 2'b00;
      for (int i = 5; i <= 11; i++) begin
         tick();
         chk($sformatf("tmo_r_quiet_e%0d", i), 32'(TIMEOUT), 32'd0);
      end
      tick();                                   // E12
      chk("tmo_r_pulse",  32'(TIMEOUT), 32'd1);
      chk("tmo_r_grant",  32'(M_GRANT), 32'h1);
      tick();
      chk("tmo_r_once",   32'(TIMEOUT), 32'd0);
      chk("tmo_r_grant0", 32'(M_GRANT), 32'h0);
      M_REQ = 2'b00;
      tick();
      tick();

      // ---------------- done beats timeout on the same edge ----------------
      M_REQ = 2'b01;
      tick();                                   // grant
      M_UTIL = 2'b01;
      tick();                                   // BUSY, count 0
      M_UTIL = 2'b00;
      for (int i = 0; i < 7; i++) tick();       // count reaches 7
      M_DONE = 2'b01;
      tick();
      M_DONE = 2'b00;
      M_REQ  = 2'b00;
      chk("done_vs_tmo_tmo",   32'(TIMEOUT), 32'd0);
      chk("done_vs_tmo_bsy",   32'(BUS_BSY), 32'd0);
      tick();
      chk("done_vs_tmo_grant", 32'(M_GRANT), 32'h0);
      chk("done_vs_tmo_tmo2",  32'(TIMEOUT), 32'd0);
      tick();
      tick();

      // ---------------- reset mid-transfer ----------------
      M_REQ = 2'b01;
      tick();
      M_UTIL    = 2'b01;
      M_BUS_OUT = 2'b01;
      M_RW      = 2'b01;
      tick();                                   // BUSY
      chk("pre_rst_s_util", 32'(S_UTIL),    32'd1);
      chk("pre_rst_s_bus",  32'(S_BUS_OUT), 32'd1);
      #2;
      RSTN = 1'b0;
      #1;
      chk_all_zero("midrst");
      chk("midrst_grant_id", 32'(GRANT_ID), 32'd0);
      M_REQ     = 2'b10;
      M_UTIL    = 2'b00;
      M_BUS_OUT = 2'b00;
      M_RW      = 2'b00;
      @(negedge CLK);
      RSTN = 1'b1;
      tick();
      chk("post_rst_grant",    32'(M_GRANT),  32'h2);
      chk("post_rst_grant_id", 32'(GRANT_ID), 32'd1);
      chk("post_rst_bsy",      32'(BUS_BSY),  32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
